inst_mem: RTL and testbench



---
 rtl/inst_mem_pkg.sv | 29 ++
 rtl/inst_mem.sv | 49 ++++
 tb/tb_inst_mem.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/inst_mem_pkg.sv
// Shared constants, default program image and address helper for the
// byte-addressed instruction memory.
package inst_mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic [31:0] NOP_INSTR = 32'h00000000;

    typedef logic [7:0] image_t [DEPTH];

    // Built-in program: addi $t0,5 / addi $t1,10 / add $t2,$t0,$t1 / sw $t2,0.
    localparam image_t DEFAULT_IMAGE = '{
        0: 8'h20,  1: 8'h08,  2: 8'h00,  3: 8'h05,
        4: 8'h20,  5: 8'h09,  6: 8'h00,  7: 8'h0A,
        8: 8'h01,  9: 8'h09, 10: 8'h50, 11: 8'h20,
        12: 8'hAC, 13: 8'h0A, 14: 8'h00, 15: 8'h00,
        default: 8'h00
    };

    // The byte-address width equals log2(DEPTH), so plain truncation wraps.
    function automatic logic [ADDR_W-1:0] addr_inc(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] offset
    );
        return base + offset;
    endfunction

endpackage

// File: rtl/inst_mem.sv
// Byte-addressed instruction memory with combinational big-endian 32-bit read.
// Optional byte-write port compiled in with INST_MEM_WRITE_EN.
module inst_mem
    import inst_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       instruction
`ifdef INST_MEM_WRITE_EN
    ,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data
`endif
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_bytes [4];

    // Each byte is its own register so the whole image can reload in one edge.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_byte
            logic [7:0] byte_reg = DEFAULT_IMAGE[gi];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    byte_reg <= DEFAULT_IMAGE[gi];
                end
`ifdef INST_MEM_WRITE_EN
                else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    byte_reg <= wr_data;
                end
`endif
            end

            assign mem[gi] = byte_reg;
        end

        for (gi = 0; gi < 4; gi++) begin : g_rd
            assign rd_bytes[gi] = mem[addr_inc(addr, ADDR_W'(gi))];
        end
    endgenerate

    assign instruction = rst_n ? {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]}
                               : NOP_INSTR;

endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench for inst_mem: directed test-plan cases plus randomized
// reads, resets and (when INST_MEM_WRITE_EN is defined) byte writes.
module tb_inst_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr;
    logic [31:0] instruction;
`ifdef INST_MEM_WRITE_EN
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
`endif

    logic [7:0] ref_mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_mem dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .instruction(instruction)
`ifdef INST_MEM_WRITE_EN
        ,
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s addr=%0d got %08h expected %08h", tag, addr, got, exp);
        end
    endtask

    task automatic load_default();
        logic [31:0] words [4];
        words[0] = 32'h20080005;
        words[1] = 32'h2009000A;
        words[2] = 32'h01095020;
        words[3] = 32'hAC0A0000;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 4; b++)
                ref_mem[4*k+b] = 8'((words[k] >> (24 - 8*b)) & 32'hFF);
    endtask

    function automatic logic [31:0] model_read(input int a);
        if (rst_n !== 1'b1) return 32'h0;
        return {ref_mem[a % 256], ref_mem[(a+1) % 256],
                ref_mem[(a+2) % 256], ref_mem[(a+3) % 256]};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) load_default();
`ifdef INST_MEM_WRITE_EN
        else if (wr_en) ref_mem[wr_addr] = wr_data;
`endif
        #1;
    endtask

    task automatic read_at(input string tag, input logic [7:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, instruction, exp);
        check({tag, "_model"}, instruction, model_read(int'(a)));
        $display("read %s addr=%0d instr=%08h", tag, a, instruction);
    endtask

    initial begin
        load_default();
        rst_n = 1'b0;
        addr  = 8'd0;
`ifdef INST_MEM_WRITE_EN
        wr_en = 1'b0; wr_addr = 8'd0; wr_data = 8'd0;
`endif
        #1;
        check("rst_mask_pre", instruction, 32'h0);
        tick();
        tick();
        read_at("rst_mask_254", 8'd254, 32'h0);

        rst_n = 1'b1;
        read_at("first_fetch", 8'd0, 32'h20080005);
        read_at("unaligned3", 8'd3, 32'h05200900);
        read_at("aligned8", 8'd8, 32'h01095020);
        read_at("wrap254", 8'd254, 32'h00002008);
        read_at("wrap255", 8'd255, 32'h00200800);

`ifdef INST_MEM_WRITE_EN
        read_at("wr_before", 8'd16, 32'h00000000);
        wr_en = 1'b1; wr_addr = 8'd17; wr_data = 8'hFF;
        #1;
        check("wr_pre_edge", instruction, 32'h00000000);
        tick();
        wr_en = 1'b0;
        read_at("wr_after", 8'd16, 32'h00FF0000);

        rst_n = 1'b0; wr_en = 1'b1; wr_addr = 8'd1; wr_data = 8'h55;
        tick();
        rst_n = 1'b1; wr_en = 1'b0;
        read_at("wr_vs_rst", 8'd0, 32'h20080005);
        read_at("rst_undo_wr", 8'd16, 32'h00000000);

        wr_en = 1'b1; wr_addr = 8'd0; wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        read_at("corrupt", 8'd0, 32'h77080005);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        read_at("reload", 8'd0, 32'h20080005);
`endif

        for (int it = 0; it < 400; it++) begin
            addr  = 8'($urandom_range(0, 255));
            rst_n = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
`ifdef INST_MEM_WRITE_EN
            wr_en   = $urandom_range(0, 1) == 1;
            wr_addr = ($urandom_range(0, 1) == 1) ? 8'(addr + 8'($urandom_range(0, 3)))
                                                  : 8'($urandom_range(0, 255));
            wr_data = 8'($urandom_range(0, 255));
`endif
            #1;
            check("rand_pre", instruction, model_read(int'(addr)));
            tick();
            check("rand_post", instruction, model_read(int'(addr)));
            $display("rand it=%0d addr=%0d rst_n=%0b instr=%08h", it, addr, rst_n, instruction);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
